// File: rtl/addr_gen_multi.sv
// Multi-counter address generator: base counter + series register + offset, 3-stage request pipeline.
// Define ADDR_GEN_WRAP_EN to make each counter wrap back to its start at the end of its region.
module addr_gen_multi #(
    parameter int ADDR_WIDTH   = 9,
    parameter int N_CNT        = 4,
    parameter int OFFSET_WIDTH = 4,
    parameter logic [N_CNT*ADDR_WIDTH-1:0] CNT_START = {9'd192, 9'd128, 9'd64, 9'd0},
    parameter logic [N_CNT*ADDR_WIDTH-1:0] CNT_INC   = {4{9'd8}},
    parameter logic [N_CNT*ADDR_WIDTH-1:0] CNT_LEN   = {4{9'd64}},
    parameter int SERIES_INC   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [$clog2(N_CNT)-1:0] cnt_sel,
    input  logic [OFFSET_WIDTH-1:0]  offset,
    input  logic [N_CNT-1:0]         cnt_inc,
    input  logic [N_CNT-1:0]         cnt_rst,
    input  logic                     series_inc,
    input  logic                     series_rst,
    output logic [ADDR_WIDTH-1:0]    addr_out,
    output logic                     addr_valid,
    output logic [N_CNT-1:0]         wrap_pulse
);

    localparam logic [ADDR_WIDTH-1:0] SERIES_STEP = ADDR_WIDTH'(SERIES_INC);

    function automatic logic [ADDR_WIDTH-1:0] add_mod(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] b);
        return a + b;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] field(input logic [N_CNT*ADDR_WIDTH-1:0] vec,
                                                    input int idx);
        return vec[idx*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    logic [ADDR_WIDTH-1:0]   cnt [N_CNT];
    logic [ADDR_WIDTH-1:0]   series_r;
    logic                    series_inc_r;
    logic                    series_rst_r;
    logic [N_CNT-1:0]        wrap_r;

    logic [ADDR_WIDTH-1:0]   base_p0;
    logic [OFFSET_WIDTH-1:0] off_p0;
    logic                    vld_p0;
    logic [ADDR_WIDTH-1:0]   sum_p1;
    logic [OFFSET_WIDTH-1:0] off_p1;
    logic                    vld_p1;
    logic [ADDR_WIDTH-1:0]   addr_p2;
    logic                    vld_p2;

    // Counter bank and series register; rst overrides every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) cnt[i] <= field(CNT_START, i);
            wrap_r       <= '0;
            series_r     <= '0;
            series_inc_r <= 1'b0;
            series_rst_r <= 1'b0;
        end else begin
            wrap_r <= '0;
            for (int i = 0; i < N_CNT; i++) begin
                if (cnt_rst[i]) begin
                    cnt[i] <= field(CNT_START, i);
                end else if (cnt_inc[i]) begin
`ifdef ADDR_GEN_WRAP_EN
                    // One extra bit so a region ending at 2^ADDR_WIDTH still compares correctly.
                    if (({1'b0, cnt[i]} + {1'b0, field(CNT_INC, i)}) >=
                        ({1'b0, field(CNT_START, i)} + {1'b0, field(CNT_LEN, i)})) begin
                        cnt[i]    <= field(CNT_START, i);
                        wrap_r[i] <= 1'b1;
                    end else begin
                        cnt[i] <= add_mod(cnt[i], field(CNT_INC, i));
                    end
`else
                    cnt[i] <= add_mod(cnt[i], field(CNT_INC, i));
`endif
                end
            end
            series_inc_r <= series_inc;
            series_rst_r <= series_rst;
            if (series_rst_r) begin
                series_r <= '0;
            end else if (series_inc_r) begin
                series_r <= add_mod(series_r, SERIES_STEP);
            end
        end
    end

`ifdef ADDR_GEN_WRAP_EN
    assign wrap_pulse = wrap_r;
`else
    assign wrap_pulse = '0;
`endif

    // Pipeline control: valids and the held output address.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            addr_p2 <= '0;
        end else begin
            vld_p0 <= req_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) addr_p2 <= add_mod(sum_p1, ADDR_WIDTH'(off_p1));
        end
    end

    // S1: sample base counter before this cycle's counter update
    always_ff @(posedge clk) begin
        base_p0 <= cnt[cnt_sel];
        off_p0  <= offset;
        // S2: add series register as it stands now
        sum_p1  <= add_mod(base_p0, series_r);
        off_p1  <= off_p0;
    end

    assign addr_out   = addr_p2;
    assign addr_valid = vld_p2;

endmodule

// File: tb/tb_addr_gen_multi.sv
// Directed bench for addr_gen_multi; expectations follow ADDR_GEN_WRAP_EN when it is defined.
module tb_addr_gen_multi;

`ifdef ADDR_GEN_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] cnt_sel;
    logic [3:0] offset;
    logic [3:0] cnt_inc;
    logic [3:0] cnt_rst;
    logic       series_inc;
    logic       series_rst;
    logic [8:0] addr_out;
    logic       addr_valid;
    logic [3:0] wrap_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    addr_gen_multi dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .cnt_sel    (cnt_sel),
        .offset     (offset),
        .cnt_inc    (cnt_inc),
        .cnt_rst    (cnt_rst),
        .series_inc (series_inc),
        .series_rst (series_rst),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One request in the current cycle, then check the result three cycles later.
    task automatic run_req(input logic [1:0] sel, input logic [3:0] off,
                           input logic [31:0] exp, input string tag);
        req_valid = 1'b1;
        cnt_sel   = sel;
        offset    = off;
        step();
        req_valid = 1'b0;
        step();
        check({tag, "_early"}, 32'(addr_valid), 32'd0);
        step();
        check({tag, "_vld"}, 32'(addr_valid), 32'd1);
        check({tag, "_addr"}, 32'(addr_out), exp);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        cnt_sel    = '0;
        offset     = '0;
        cnt_inc    = '0;
        cnt_rst    = '0;
        series_inc = 1'b0;
        series_rst = 1'b0;
        step();
        step();
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_addr",  32'(addr_out),   32'd0);
        check("rst_wrap",  32'(wrap_pulse), 32'd0);
        rst = 1'b0;

        // Basic request: counter 1 (64) + offset 3, then output holds
        run_req(2'd1, 4'd3, 32'd67, "basic");
        step();
        check("basic_drop", 32'(addr_valid), 32'd0);
        check("basic_hold", 32'(addr_out),   32'd67);

        // Eight increments of counter 0
        cnt_inc = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("wrap_k%0d", k), 32'(wrap_pulse[0]), (k == 8 && WRAP) ? 32'd1 : 32'd0);
        end
        cnt_inc = '0;
        step();
        check("wrap_clear", 32'(wrap_pulse), 32'd0);
        run_req(2'd0, 4'd0, WRAP ? 32'd0 : 32'd64, "cnt0_after8");

        cnt_rst = 4'b0001;
        step();
        cnt_rst = '0;

        // Series increment, request two cycles later
        series_inc = 1'b1;
        step();
        series_inc = 1'b0;
        step();
        run_req(2'd0, 4'd0, 32'd16, "series1");

        // Back-to-back requests straddling a series update
        series_inc = 1'b1;
        req_valid  = 1'b1;
        cnt_sel    = 2'd0;
        offset     = 4'd0;
        step();
        series_inc = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("b2b_a_vld",  32'(addr_valid), 32'd1);
        check("b2b_a_addr", 32'(addr_out),   32'd16);
        step();
        check("b2b_b_vld",  32'(addr_valid), 32'd1);
        check("b2b_b_addr", 32'(addr_out),   32'd32);

        // Simultaneous series strobes: clear wins
        series_inc = 1'b1;
        series_rst = 1'b1;
        step();
        series_inc = 1'b0;
        series_rst = 1'b0;
        step();
        run_req(2'd0, 4'd0, 32'd0, "series_clr");

        // Same-cycle increment is not seen by the request; next request sees it
        req_valid = 1'b1;
        cnt_sel   = 2'd2;
        offset    = 4'd0;
        cnt_inc   = 4'b0100;
        step();
        cnt_inc = '0;
        step();
        req_valid = 1'b0;
        step();
        check("c2_first",  32'(addr_out), 32'd128);
        step();
        check("c2_second", 32'(addr_out), 32'd136);
        step();
        check("c2_idle", 32'(addr_valid), 32'd0);
        cnt_inc = 4'b0100;
        cnt_rst = 4'b0100;
        step();
        cnt_inc = '0;
        cnt_rst = '0;
        run_req(2'd2, 4'd0, 32'd128, "c2_rst_prio");

        // Series 320: 192 + 320 + 15 wraps to 15
        series_inc = 1'b1;
        repeat (20) step();
        series_inc = 1'b0;
        step();
        step();
        run_req(2'd3, 4'd15, 32'd15, "modwrap");

        // Reset mid-flight discards the request and overrides other strobes
        req_valid = 1'b1;
        cnt_sel   = 2'd1;
        offset    = 4'd0;
        step();
        req_valid  = 1'b0;
        rst        = 1'b1;
        cnt_inc    = 4'b0010;
        series_inc = 1'b1;
        step();
        rst        = 1'b0;
        cnt_inc    = '0;
        series_inc = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("flush_vld_t%0d", k),  32'(addr_valid), 32'd0);
            check($sformatf("flush_addr_t%0d", k), 32'(addr_out),   32'd0);
            step();
        end
        run_req(2'd1, 4'd0, 32'd64, "rst_override");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
